// File: rtl/collision_scanner_if.sv
// Bus bundle between the object position logic / game FSM (master) and the
// collision scanner (slave). Car coordinates are packed, car i at [i*COORD_W +: COORD_W].
interface collision_scanner_if #(
    parameter int NUM_CARS = 4,
    parameter int COORD_W  = 10,
    parameter int IDX_W    = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
);
    logic                          frame_tick;
    logic [COORD_W-1:0]            frog_x;
    logic [COORD_W-1:0]            frog_y;
    logic [NUM_CARS*COORD_W-1:0]   car_x;
    logic [NUM_CARS*COORD_W-1:0]   car_y;
    logic [NUM_CARS-1:0]           car_en;
    logic                          busy;
    logic                          death_collision;
    logic                          win_collision;
    logic [IDX_W-1:0]              hit_index;
    logic                          grace_active;

    modport master (
        output frame_tick, frog_x, frog_y, car_x, car_y, car_en,
        input  busy, death_collision, win_collision, hit_index, grace_active
    );

    modport slave (
        input  frame_tick, frog_x, frog_y, car_x, car_y, car_en,
        output busy, death_collision, win_collision, hit_index, grace_active
    );
endinterface

// File: rtl/collision_scanner.sv
// Multi-car frog collision scanner: on each accepted frame_tick it snapshots the
// frog position, checks one car hitbox per clock (lowest hit index wins) and then
// emits a one-cycle death or win pulse in its REPORT cycle.
// Optional macro COLLISION_GRACE_EN adds a post-death window of GRACE_FRM frames
// during which death is suppressed; without it grace_active is tied low.
module collision_scanner #(
    parameter int NUM_CARS  = 4,
    parameter int COORD_W   = 10,
    parameter int TILE_SIZE = 32,
    parameter int WIN_Y     = 0,
    parameter int GRACE_FRM = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    collision_scanner_if.slave bus
);
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [COORD_W:0] TILE_EXT = (COORD_W+1)'(TILE_SIZE);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   car_cnt;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   hit_index_q;
    logic               hit_flag;
    logic [COORD_W-1:0] frog_x_p0;
    logic [COORD_W-1:0] frog_y_p0;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               start;
    logic               last_car;
    logic               car_hit;
    logic               suppress;
    logic               busy;
    logic               death;
    logic               win;

    // One-axis hitbox test, widened by one bit so c + TILE_SIZE cannot wrap
    function automatic logic in_span(input logic [COORD_W-1:0] f, input logic [COORD_W-1:0] c);
        logic [COORD_W:0] f_w;
        logic [COORD_W:0] c_w;
        f_w = {1'b0, f};
        c_w = {1'b0, c};
        return (f_w >= c_w) && (f_w < c_w + TILE_EXT);
    endfunction

    assign start    = (state == IDLE) && bus.frame_tick;
    assign last_car = (car_cnt == IDX_W'(NUM_CARS - 1));
    assign cur_x    = bus.car_x[int'(car_cnt)*COORD_W +: COORD_W];
    assign cur_y    = bus.car_y[int'(car_cnt)*COORD_W +: COORD_W];
    assign car_hit  = bus.car_en[car_cnt] && in_span(frog_x_p0, cur_x) && in_span(frog_y_p0, cur_y);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: tick starts a scan, last car ends it, report lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.frame_tick) state_nxt = SCAN;
            SCAN:    if (last_car)       state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: pulses only in REPORT, suppression applied before win precedence
    always_comb begin
        busy  = 1'b0;
        death = 1'b0;
        win   = 1'b0;
        if (state != IDLE) busy = 1'b1;
        if (state == REPORT) begin
            death = hit_flag && !suppress;
            win   = (frog_y_p0 == COORD_W'(WIN_Y)) && !death;
        end
    end

    // Scan control: car counter and first-hit capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            car_cnt   <= '0;
            hit_flag  <= 1'b0;
            first_idx <= '0;
        end else if (start) begin
            car_cnt  <= '0;
            hit_flag <= 1'b0;
        end else if (state == SCAN) begin
            if (car_hit && !hit_flag) begin
                hit_flag  <= 1'b1;
                first_idx <= car_cnt;
            end
            if (!last_car) car_cnt <= car_cnt + 1'b1;
        end
    end

    // Frog snapshot taken when a scan is accepted; later frog moves are ignored
    always_ff @(posedge clk) begin
        if (start) begin
            frog_x_p0 <= bus.frog_x;
            frog_y_p0 <= bus.frog_y;
        end
    end

    // Held hit index, refreshed only by a reported death
    always_ff @(posedge clk) begin
        if (!rst_n)     hit_index_q <= '0;
        else if (death) hit_index_q <= first_idx;
    end

`ifdef COLLISION_GRACE_EN
    localparam int GRACE_W = (GRACE_FRM > 1) ? $clog2(GRACE_FRM + 1) : 1;

    logic [GRACE_W-1:0] grace_cnt;
    logic               suppress_q;

    // Grace window: reload on death, count down per accepted frame; suppression
    // is decided by the window state at the moment the frame is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grace_cnt  <= '0;
            suppress_q <= 1'b0;
        end else begin
            if (start) suppress_q <= (grace_cnt != '0);
            if (death)
                grace_cnt <= GRACE_W'(GRACE_FRM);
            else if (start && grace_cnt != '0)
                grace_cnt <= grace_cnt - 1'b1;
        end
    end

    assign suppress         = suppress_q;
    assign bus.grace_active = (grace_cnt != '0);
`else
    assign suppress         = 1'b0;
    assign bus.grace_active = 1'b0;
`endif

    assign bus.busy            = busy;
    assign bus.death_collision = death;
    assign bus.win_collision   = win;
    assign bus.hit_index       = death ? first_idx : hit_index_q;
endmodule
